// File: rtl/cache_refill_mux.sv
// Blocking L1 read-miss refill controller: serves hits in one cycle, otherwise fetches the
// line from L2 and returns the critical word. Optional miss counter: CACHE_REFILL_MISS_CNT_EN.
module cache_refill_mux #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic                              hit,
  input  logic [DATA_W-1:0]                 l1_rdata,
  output logic                              l2_req_valid,
  input  logic                              l2_req_ready,
  output logic [ADDR_W-1:0]                 l2_req_addr,
  input  logic                              l2_rvalid,
  input  logic [DATA_W-1:0]                 l2_rdata,
  output logic                              fill_we,
  output logic [$clog2(LINE_WORDS)-1:0]     fill_idx,
  output logic [DATA_W-1:0]                 fill_data,
  output logic                              rvalid,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              stall,
  output logic [31:0]                       miss_count
);

  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int BOFF_W = $clog2(DATA_W / 8);
  localparam int LOW_W  = IDX_W + BOFF_W;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]  ONE_IDX   = IDX_W'(1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((LINE_WORDS * (DATA_W / 8)) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state_r;
  state_t             next_s;
  logic [IDX_W-1:0]   beat_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [IDX_W-1:0]   crit_idx_s;
  logic [DATA_W-1:0]  crit_r;
  logic               rvalid_r;
  logic [DATA_W-1:0]  rdata_r;

  // Full miss address is kept; the line base and word offset are both carved out of it.
  assign crit_idx_s = addr_r[LOW_W-1:BOFF_W];

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid && !hit) begin
          next_s = REQ;
        end else begin
          next_s = IDLE;
        end
      end
      REQ: begin
        if (l2_req_ready) begin
          next_s = FILL;
        end else begin
          next_s = REQ;
        end
      end
      FILL: begin
        if (l2_rvalid && (beat_r == LAST_IDX)) begin
          next_s = RESP;
        end else begin
          next_s = FILL;
        end
      end
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Handshake and fill-port outputs; all forced quiet while reset is held.
  always_comb begin
    l2_req_valid = 1'b0;
    fill_we      = 1'b0;
    stall        = 1'b0;
    if (reset) begin
      l2_req_valid = 1'b0;
      fill_we      = 1'b0;
      stall        = 1'b0;
    end else begin
      l2_req_valid = (state_r == REQ);
      fill_we      = (state_r == FILL) && l2_rvalid;
      stall        = (state_r == REQ) || (state_r == FILL) ||
                     ((state_r == IDLE) && req_valid && !hit);
    end
  end

  assign fill_idx    = beat_r;
  assign fill_data   = l2_rdata;
  assign l2_req_addr = addr_r & ~LINE_MASK;
  assign rvalid      = rvalid_r;
  assign rdata       = rdata_r;

  // State, beat counter, miss address, critical word and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      beat_r   <= '0;
      addr_r   <= '0;
      crit_r   <= '0;
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      state_r  <= next_s;
      rvalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && hit) begin
            rvalid_r <= 1'b1;
            rdata_r  <= l1_rdata;
          end else if (req_valid) begin
            addr_r <= req_addr;
          end
        end
        REQ: begin
          if (l2_req_ready) begin
            beat_r <= '0;
          end
        end
        FILL: begin
          if (l2_rvalid) begin
            beat_r <= beat_r + ONE_IDX;
            if (beat_r == crit_idx_s) begin
              crit_r <= l2_rdata;
            end
            // The critical word may arrive on the final beat, so bypass crit_r then.
            if (beat_r == LAST_IDX) begin
              rvalid_r <= 1'b1;
              rdata_r  <= (beat_r == crit_idx_s) ? l2_rdata : crit_r;
            end
          end
        end
        default: begin
          rvalid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_REFILL_MISS_CNT_EN
  logic [31:0] miss_cnt_r;
  logic        miss_s;

  assign miss_s = (state_r == IDLE) && req_valid && !hit;

  // Saturating count of IDLE->REQ transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_cnt_r <= 32'd0;
    end else if (miss_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
      miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end

  assign miss_count = miss_cnt_r;
`else
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_refill_mux.sv
// Scoreboard bench for cache_refill_mux (default parameters): stimulus queues expected
// responses and fill writes, a negedge monitor pops and compares them.
module tb_cache_refill_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        hit;
  logic [31:0] l1_rdata;
  logic        l2_req_valid;
  logic        l2_req_ready;
  logic [31:0] l2_req_addr;
  logic        l2_rvalid;
  logic [31:0] l2_rdata;
  logic        fill_we;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic [31:0] miss_count;

  int total = 0;
  int bad   = 0;
  int fill_seen = 0;
  bit mon_en = 1'b0;

  logic [31:0] resp_q[$];
  logic [33:0] fill_q[$];

  cache_refill_mux dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
    .l1_rdata(l1_rdata), .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_req_addr(l2_req_addr), .l2_rvalid(l2_rvalid), .l2_rdata(l2_rdata),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .rvalid(rvalid),
    .rdata(rdata), .stall(stall), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every observed response / fill write must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_rvalid", {32'd0, rdata}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          chk("resp_data", {32'd0, rdata}, {32'd0, resp_q.pop_front()});
        end
      end
      if (fill_we) begin
        fill_seen++;
        if (fill_q.size() == 0) begin
          chk("unexpected_fill", {30'd0, fill_idx, fill_data}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          chk("fill_idx_data", {30'd0, fill_idx, fill_data}, {30'd0, fill_q.pop_front()});
        end
      end
    end
  end

  task automatic do_hit(input logic [31:0] data);
    cyc();
    req_valid = 1'b1; hit = 1'b1; l1_rdata = data;
    resp_q.push_back(data);
    @(negedge clk);
    chk("hit_stall", {63'd0, stall}, 64'd0);
    cyc();
    req_valid = 1'b0; hit = 1'b0;
    @(negedge clk);
    chk("hit_rvalid", {63'd0, rvalid}, 64'd1);
    chk("hit_stall2", {63'd0, stall}, 64'd0);
  endtask

  // Full miss; ends in the RESP cycle so the caller can present a request right after.
  task automatic run_miss(input logic [31:0] addr, input int ready_wait, input bit gapped,
                          input logic [31:0] base);
    logic [1:0]  crit;
    logic [31:0] line;
    int beat;
    int start_fills;
    bit on;
    crit = addr[3:2];
    line = addr & 32'hFFFF_FFF0;
    start_fills = fill_seen;
    cyc();
    req_valid = 1'b1; hit = 1'b0; req_addr = addr;
    @(negedge clk);
    chk("miss_stall_idle", {63'd0, stall}, 64'd1);
    chk("miss_l2v_idle", {63'd0, l2_req_valid}, 64'd0);
    for (int i = 0; i <= ready_wait; i++) begin
      cyc();
      // Requests and refill beats outside their states must be ignored.
      req_valid = 1'b1; hit = 1'b1; l1_rdata = 32'h5555_0000;
      req_addr = 32'hFFFF_FFFF;
      l2_rvalid = 1'b1; l2_rdata = 32'hBAD0_0000;
      l2_req_ready = (i == ready_wait);
      @(negedge clk);
      chk("req_l2v", {63'd0, l2_req_valid}, 64'd1);
      chk("req_addr", {32'd0, l2_req_addr}, {32'd0, line});
      chk("req_stall", {63'd0, stall}, 64'd1);
    end
    beat = 0;
    on = 1'b1;
    for (int g = 0; g < 20 && beat < 4; g++) begin
      cyc();
      l2_req_ready = 1'b0;
      if (gapped && !on) begin
        l2_rvalid = 1'b0; l2_rdata = 32'hBAD1_0000;
      end else begin
        l2_rvalid = 1'b1; l2_rdata = base + beat;
        fill_q.push_back({beat[1:0], base + beat});
        if (beat == int'(crit)) resp_q.push_back(base + beat);
        beat++;
      end
      on = !on;
      @(negedge clk);
      chk("fill_stall", {63'd0, stall}, 64'd1);
      chk("fill_no_rvalid", {63'd0, rvalid}, 64'd0);
    end
    cyc();
    l2_rvalid = 1'b0; req_valid = 1'b0; hit = 1'b0;
    @(negedge clk);
    chk("resp_rvalid", {63'd0, rvalid}, 64'd1);
    chk("resp_stall", {63'd0, stall}, 64'd0);
    chk("resp_fill_we", {63'd0, fill_we}, 64'd0);
    chk("fill_pulses", 64'(fill_seen - start_fills), 64'd4);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b1; hit = 1'b0; req_addr = 32'h0; l1_rdata = 32'h0;
    l2_req_ready = 1'b0; l2_rvalid = 1'b0; l2_rdata = 32'h0;
    cyc();
    mon_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_l2v", {63'd0, l2_req_valid}, 64'd0);
    chk("rst_fill_we", {63'd0, fill_we}, 64'd0);
    chk("rst_miss_count", {32'd0, miss_count}, 64'd0);
    cyc();
    reset = 1'b0; req_valid = 1'b0;

    do_hit(32'hCAFE_0001);

    // Abort a refill after two beats.
    cyc();
    req_valid = 1'b1; hit = 1'b0; req_addr = 32'h0000_200C;
    cyc();
    req_valid = 1'b0; l2_req_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      cyc();
      l2_req_ready = 1'b0; l2_rvalid = 1'b1; l2_rdata = 32'h0000_00E0 + b;
      fill_q.push_back({b[1:0], 32'h0000_00E0 + b});
    end
    cyc();
    reset = 1'b1; l2_rdata = 32'hBAD2_0000;
    @(negedge clk);
    chk("abort_fill_we", {63'd0, fill_we}, 64'd0);
    chk("abort_stall", {63'd0, stall}, 64'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_fill_we", {63'd0, fill_we}, 64'd0);
    chk("abort_idle_stall", {63'd0, stall}, 64'd0);
    chk("abort_l2v", {63'd0, l2_req_valid}, 64'd0);
    cyc();
    l2_rvalid = 1'b0;
    do_hit(32'h1111_0002);

    run_miss(32'h0000_1238, 2, 1'b0, 32'h0000_00A0);
    do_hit(32'h2222_0003);
    run_miss(32'h0000_0104, 0, 1'b1, 32'h0000_00B0);
    do_hit(32'h3333_0004);
    run_miss(32'h0000_ABCC, 1, 1'b0, 32'h0000_00C0);
    do_hit(32'h4444_0005);
    do_hit(32'h5555_0006);

    cyc();
    @(negedge clk);
`ifdef CACHE_REFILL_MISS_CNT_EN
    chk("miss_count", {32'd0, miss_count}, 64'd3);
`else
    chk("miss_count", {32'd0, miss_count}, 64'd0);
`endif
    chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
    chk("fill_q_drained", 64'(fill_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
